bp_be_long_wb_queue: RTL and testbench

- Sits directly downstream of the long-latency (iterative divide) pipe in the BE calculator.
- Captures its writeback packets in a small FIFO and drains them to the shared integer regfile write port whenever the main pipeline is not writing.
- Keeps a per-register scoreboard of outstanding long-op destinations and gives the issue stage combinational RAW/WAW hazard detection plus issue credit (ready_o).

---
 rtl/bp_be_long_wb_queue.sv | 185 ++++++++++++++++++
 tb/tb_bp_be_long_wb_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_long_wb_queue.sv
// ---------------------------------------------------------------------------
// bp_be_long_wb_queue
//
// Writeback queue for the long-latency (iterative divide) pipe. Results from
// the long pipe are captured in a small circular FIFO and written to the
// shared integer regfile port on any cycle the main pipeline leaves it free.
// A per-register scoreboard of outstanding long-op destinations gives the
// issue stage combinational RAW/WAW hazard detection. A credit counter limits
// the number of long ops in flight to the FIFO depth.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   issue_v_i              long op accepted by the long pipe this cycle
//   issue_rd_addr_i        destination of that op
//   ready_o                long-op issue permitted (credit available)
//   long_v_i               result valid from long pipe (no backpressure)
//   long_rd_addr_i/data_i  result destination / data
//   int_wb_v_i             main pipeline owns the regfile write port
//   wb_v_o                 regfile write enable from this block
//   wb_rd_addr_o/data_o    regfile write address / data (FIFO head)
//   probe_rs1/rs2/rd_addr_i operands of the instruction in issue
//   hazard_o               that instruction touches a pending destination
//
// Handshake semantics: issue_v_i is a valid qualified by ready_o; the issue
// side may only pulse issue_v_i when ready_o=1 (or when a writeback returns a
// credit in the same cycle). long_v_i has no ready: it is always accepted,
// which is safe because credit is reserved at issue. wb_v_o is a valid with
// an implicit ready of ~int_wb_v_i folded in: the head is consumed on every
// cycle wb_v_o=1.
// ---------------------------------------------------------------------------
module bp_be_long_wb_queue #(
    parameter int reg_addr_width_p = 5,
    parameter int dword_width_p    = 64,
    parameter int els_p            = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        issue_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rd_addr_i,
    output logic                        ready_o,

    input  logic                        long_v_i,
    input  logic [reg_addr_width_p-1:0] long_rd_addr_i,
    input  logic [dword_width_p-1:0]    long_rd_data_i,

    input  logic                        int_wb_v_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    output logic [dword_width_p-1:0]    wb_rd_data_o,

    input  logic [reg_addr_width_p-1:0] probe_rs1_addr_i,
    input  logic [reg_addr_width_p-1:0] probe_rs2_addr_i,
    input  logic [reg_addr_width_p-1:0] probe_rd_addr_i,
    output logic                        hazard_o
);

    localparam int ptr_w_lp    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp    = $clog2(els_p + 1);
    localparam int num_regs_lp = 1 << reg_addr_width_p;

    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp  = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] one_cnt_lp  = cnt_w_lp'(1);

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    logic [reg_addr_width_p-1:0] addr_mem [els_p];
    logic [dword_width_p-1:0]    data_mem [els_p];

    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [cnt_w_lp-1:0] occ_r;

    logic enq;
    logic deq;
    logic empty;
    logic full;

    assign empty  = (occ_r == '0);
    assign full   = (occ_r == max_cnt_lp);
    assign enq    = long_v_i;
    // Main pipe always wins the port; the head drains on the first free cycle.
    assign wb_v_o = ~empty & ~int_wb_v_i;
    assign deq    = wb_v_o;

    // Head is read straight from storage, so a freshly enqueued result is
    // only visible the cycle after long_v_i (no bypass path).
    assign wb_rd_addr_o = addr_mem[rd_ptr_r];
    assign wb_rd_data_o = data_mem[rd_ptr_r];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_mem[wr_ptr_r] <= long_rd_addr_i;
            data_mem[wr_ptr_r] <= long_rd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
            end
            if (deq) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   occ_r <= occ_r + one_cnt_lp;
                2'b01:   occ_r <= occ_r - one_cnt_lp;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue credit: one per op from issue until its writeback
    // -----------------------------------------------------------------------
    logic [cnt_w_lp-1:0] credit_r;

    assign ready_o = (credit_r < max_cnt_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credit_r <= '0;
        end else begin
            case ({issue_v_i, deq})
                2'b10:   credit_r <= credit_r + one_cnt_lp;
                2'b01:   credit_r <= credit_r - one_cnt_lp;
                default: credit_r <= credit_r;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Destination scoreboard
    // -----------------------------------------------------------------------
    logic [num_regs_lp-1:0] sb_r;
    logic [num_regs_lp-1:0] sb_n;

    // Set is applied after clear so a new issue to the register being written
    // back this cycle keeps its pending bit. x0 never becomes pending.
    always_comb begin
        sb_n = sb_r;
        if (deq) begin
            sb_n[wb_rd_addr_o] = 1'b0;
        end
        if (issue_v_i) begin
            sb_n[issue_rd_addr_i] = 1'b1;
        end
        sb_n[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sb_r <= '0;
        end else begin
            sb_r <= sb_n;
        end
    end

    // Registered scoreboard only: this cycle's set/clear are not forwarded.
    // Checking rd as well blocks WAW, so a register never has two pending
    // writes in the queue.
    assign hazard_o = sb_r[probe_rs1_addr_i]
                    | sb_r[probe_rs2_addr_i]
                    | sb_r[probe_rd_addr_i];

    // -----------------------------------------------------------------------
    // Protocol checks
    // -----------------------------------------------------------------------
    // A full FIFO can still accept a result when the head drains that cycle.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(long_v_i && full && !deq));

    // Issue needs a free credit; a credit returned by a same-cycle writeback
    // counts, leaving the count unchanged.
    a_issue_credit: assert property (@(posedge clk_i) disable iff (reset_i)
        !(issue_v_i && !ready_o && !deq));

endmodule

// File: tb/tb_bp_be_long_wb_queue.sv
// ---------------------------------------------------------------------------
// Directed bench for bp_be_long_wb_queue. Expected writebacks are pushed into
// exp_q when the long-pipe result is driven; a monitor pops and compares on
// every cycle the DUT writes back. Credit/hazard/valid expectations are
// checked inline with hand-computed values.
// ---------------------------------------------------------------------------
module tb_bp_be_long_wb_queue;

    localparam int aw_lp = 5;
    localparam int dw_lp = 64;
    localparam int w_lp  = aw_lp + dw_lp;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             issue_v;
    logic [aw_lp-1:0] issue_rd_addr;
    logic             ready;
    logic             long_v;
    logic [aw_lp-1:0] long_rd_addr;
    logic [dw_lp-1:0] long_rd_data;
    logic             int_wb_v;
    logic             wb_v;
    logic [aw_lp-1:0] wb_rd_addr;
    logic [dw_lp-1:0] wb_rd_data;
    logic [aw_lp-1:0] probe_rs1, probe_rs2, probe_rd;
    logic             hazard;

    bp_be_long_wb_queue #(
        .reg_addr_width_p(aw_lp),
        .dword_width_p   (dw_lp),
        .els_p           (2)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .issue_v_i       (issue_v),
        .issue_rd_addr_i (issue_rd_addr),
        .ready_o         (ready),
        .long_v_i        (long_v),
        .long_rd_addr_i  (long_rd_addr),
        .long_rd_data_i  (long_rd_data),
        .int_wb_v_i      (int_wb_v),
        .wb_v_o          (wb_v),
        .wb_rd_addr_o    (wb_rd_addr),
        .wb_rd_data_o    (wb_rd_data),
        .probe_rs1_addr_i(probe_rs1),
        .probe_rs2_addr_i(probe_rs2),
        .probe_rd_addr_i (probe_rd),
        .hazard_o        (hazard)
    );

    // scoreboard state
    logic [w_lp-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [dw_lp-1:0] act,
                       input logic [dw_lp-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every DUT writeback must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && wb_v === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected actual=%0h_%0h expected=none",
                         wb_rd_addr, wb_rd_data);
            end else begin
                logic [w_lp-1:0] e;
                e = exp_q.pop_front();
                if ({wb_rd_addr, wb_rd_data} !== e) begin
                    failures++;
                    $display("FAIL wb_data actual=%0h_%0h expected=%0h_%0h",
                             wb_rd_addr, wb_rd_data, e[w_lp-1:dw_lp], e[dw_lp-1:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic idle();
        issue_v = 1'b0; issue_rd_addr = '0;
        long_v = 1'b0; long_rd_addr = '0; long_rd_data = '0;
        int_wb_v = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic [aw_lp-1:0] rd);
        issue_v = 1'b1; issue_rd_addr = rd;
    endtask

    task automatic result(input logic [aw_lp-1:0] rd, input logic [dw_lp-1:0] d);
        long_v = 1'b1; long_rd_addr = rd; long_rd_data = d;
        exp_q.push_back({rd, d});
    endtask

    task automatic probe(input logic [aw_lp-1:0] a, input logic [aw_lp-1:0] b,
                         input logic [aw_lp-1:0] c);
        probe_rs1 = a; probe_rs2 = b; probe_rd = c;
    endtask

    initial begin
        idle();
        probe(5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        probe(5'd5, 5'd0, 5'd0);
        sample();
        chk("rst_wb_v", wb_v, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_ready", ready, 1);
        tick();

        // basic issue -> result -> writeback, hazard window on rs1=5
        issue(5'd5);
        sample(); chk("t1_hz_issue_cyc", hazard, 0);
        tick();
        sample(); chk("t1_hz_after_issue", hazard, 1);
        tick();
        result(5'd5, 64'h1234);
        sample(); chk("t1_no_bypass", wb_v, 0); chk("t1_hz_result_cyc", hazard, 1);
        tick();
        sample(); chk("t1_wb_v", wb_v, 1); chk("t1_hz_wb_cyc", hazard, 1);
        tick();
        sample(); chk("t1_hz_clear", hazard, 0); chk("t1_wb_idle", wb_v, 0);
        chk("t1_ready", ready, 1);
        tick();

        // main pipe holds the port for 4 cycles
        issue(5'd7);
        tick();
        result(5'd7, 64'hdead_beef_0000_0007);
        int_wb_v = 1'b1;
        sample(); chk("t2_blocked0", wb_v, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            int_wb_v = 1'b1;
            sample();
            chk("t2_blocked", wb_v, 0);
            chk("t2_held_data", wb_rd_data, 64'hdead_beef_0000_0007);
            chk("t2_held_addr", wb_rd_addr, 7);
            tick();
        end
        sample(); chk("t2_release", wb_v, 1);
        tick();
        sample(); chk("t2_drained", wb_v, 0);
        tick();

        // fill credits, then drain in order
        issue(5'd3); int_wb_v = 1'b1;
        tick();
        issue(5'd4); result(5'd3, 64'haaaa_0003); int_wb_v = 1'b1;
        sample(); chk("t3_ready_one", ready, 1);
        tick();
        result(5'd4, 64'hbbbb_0004); int_wb_v = 1'b1;
        sample(); chk("t3_ready_full", ready, 0); chk("t3_blocked", wb_v, 0);
        tick();
        sample(); chk("t3_wb_first", wb_v, 1); chk("t3_ready_still0", ready, 0);
        tick();
        sample(); chk("t3_wb_second", wb_v, 1); chk("t3_ready_back", ready, 1);
        tick();
        sample(); chk("t3_empty", wb_v, 0);
        tick();

        // issue + writeback at full credit; set/clear on the same register
        probe(5'd9, 5'd0, 5'd0);
        issue(5'd9); int_wb_v = 1'b1;
        tick();
        issue(5'd10); result(5'd9, 64'hcccc_0009); int_wb_v = 1'b1;
        tick();
        int_wb_v = 1'b1;
        sample(); chk("t4_full", ready, 0); chk("t4_blocked", wb_v, 0);
        tick();
        issue(5'd9); result(5'd10, 64'hdddd_000a);
        sample(); chk("t4_wb", wb_v, 1); chk("t4_ready_wb_cyc", ready, 0);
        chk("t4_hz", hazard, 1);
        tick();
        int_wb_v = 1'b1;
        sample(); chk("t4_count_same", ready, 0); chk("t4_bit_kept", hazard, 1);
        tick();
        result(5'd9, 64'heeee_0009);
        sample(); chk("t4_wb_rd10", wb_v, 1); chk("t4_hz_rd10", hazard, 1);
        tick();
        sample(); chk("t4_wb_rd9", wb_v, 1); chk("t4_ready_one", ready, 1);
        chk("t4_hz_pending", hazard, 1);
        tick();
        sample(); chk("t4_hz_clear", hazard, 0); chk("t4_ready_all", ready, 1);
        tick();

        // x0 destination: never a hazard, still uses credit
        probe(5'd0, 5'd0, 5'd0);
        issue(5'd0);
        tick();
        issue(5'd0);
        sample(); chk("t5_hz_x0_a", hazard, 0);
        tick();
        result(5'd0, 64'h55);
        sample(); chk("t5_ready_full", ready, 0); chk("t5_hz_x0_b", hazard, 0);
        tick();
        result(5'd0, 64'h66);
        sample(); chk("t5_wb_x0", wb_v, 1); chk("t5_hz_x0_c", hazard, 0);
        tick();
        sample(); chk("t5_wb_x0_2", wb_v, 1); chk("t5_ready_ret", ready, 1);
        tick();
        sample(); chk("t5_ready_all", ready, 1); chk("t5_idle", wb_v, 0);
        tick();

        // reset with two entries queued and bits set
        probe(5'd11, 5'd12, 5'd0);
        issue(5'd11);
        tick();
        issue(5'd12); result(5'd11, 64'h1111); int_wb_v = 1'b1;
        tick();
        result(5'd12, 64'h2222); int_wb_v = 1'b1;
        sample(); chk("t6_full", ready, 0); chk("t6_hz", hazard, 1);
        tick();
        int_wb_v = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        sample(); chk("t6_wb_v", wb_v, 0); chk("t6_hz", hazard, 0);
        chk("t6_ready", ready, 1);
        tick();
        sample(); chk("t6_wb_v_later", wb_v, 0);
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exp_q_drained actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
